seg_display_driver: RTL and testbench

- Output-side counterpart to the button front end: takes the binary LED counter value and shows it in decimal on the Nexys A7 8-digit common-anode seven-segment display.
- Converts binary to BCD with a sequential double-dabble engine, then time-multiplexes the digits using a refresh prescaler.
- Sits beside the LED counter in top; its only input is the counter value.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_display_driver_if.sv | 17 +
 rtl/bin2bcd.sv | 81 ++++++++
 rtl/seg_display_driver.sv | 92 +++++++++
 tb/tb_seg_display_driver.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and seven-segment constants for the display driver.
// Patterns are active-low with CA..CG on bits 0..6.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

  // Nibbles 10-15 never come out of the converter; show them blank anyway.
  function automatic seg_t seg_encode(input logic [3:0] nibble);
    seg_t pat;
    pat = SEG_BLANK;
    if (nibble <= 4'd9) pat = SEG_DIGIT[nibble];
    return pat;
  endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Value input and display outputs of the seven-segment driver.
// The slave side is the driver; the master side is whoever supplies the value.
interface seg_display_driver_if
  import seg_pkg::*;
#(
  parameter int B      = 4,
  parameter int DIGITS = 8
);
  logic [B-1:0]      value;
  logic [DIGITS-1:0] an;
  seg_t              seg;
  logic              dp;
  logic              busy;

  modport master (output value, input an, seg, dp, busy);
  modport slave  (input value, output an, seg, dp, busy);
endinterface

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: one bit per cycle, restarts whenever
// the input differs from the last value it converted.
module bin2bcd
  import seg_pkg::*;
#(
  parameter int B      = 4,
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [B-1:0]        value,
  output logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(B + 1);

  conv_state_t   state, state_next;
  logic [B-1:0]  bin;
  logic [B-1:0]  captured;
  logic [B-1:0]  last_value;
  logic [BW-1:0] scratch;
  logic [CW-1:0] count;

  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] x);
    logic [BW-1:0] r;
    r = x;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (value != last_value) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin        <= '0;
      captured   <= '0;
      last_value <= '0;
      scratch    <= '0;
      count      <= '0;
    end else begin
      case (state)
        LOAD: begin
          bin      <= value;
          captured <= value;
          scratch  <= '0;
          count    <= CW'(B);
        end
        SHIFT: begin
          {scratch, bin} <= {dabble_adjust(scratch), bin} << 1;
          count          <= count - 1'b1;
        end
        DONE:    last_value <= captured;
        default: ;
      endcase
    end
  end

  assign bcd  = scratch;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: rtl/seg_display_driver.sv
// Shows a binary value in decimal on a multiplexed common-anode display:
// BCD conversion, refresh prescaler, digit scan, leading-zero blanking.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int B             = 4,
  parameter int DIGITS        = 8,
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input logic                 clk,
  input logic                 reset,
  seg_display_driver_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BW-1:0]     scratch;
  logic [BW-1:0]     disp;
  logic              conv_busy;
  logic              conv_done;
  logic [PW-1:0]     presc;
  logic [IW-1:0]     index;
  logic [DIGITS-1:0] zero_from;
  logic [3:0]        nibble;
  logic              blank;
  logic [DIGITS-1:0] an_r;
  seg_t              seg_r;

  bin2bcd #(.B(B), .DIGITS(DIGITS)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .value (bus.value),
    .bcd   (scratch),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  // The display register only ever takes a finished conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          disp <= '0;
    else if (conv_done) disp <= scratch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      index <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      index <= (index == IW'(DIGITS - 1)) ? '0 : index + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // zero_from[k] is set when nibbles k..DIGITS-1 are all zero.
  always_comb begin
    zero_from = '0;
    nibble    = '0;
    blank     = 1'b0;
    zero_from[DIGITS-1] = (disp[4*(DIGITS-1) +: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (disp[4*k +: 4] == 4'd0);
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == index) begin
        nibble = disp[4*k +: 4];
        blank  = (BLANK_LEADING != 0) && (k != 0) && zero_from[k];
      end
    end
  end

  // Anode and cathode registers load on the same edge so they never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r  <= '1;
      seg_r <= SEG_BLANK;
    end else begin
      an_r  <= ~(DIGITS'(1) << index);
      seg_r <= blank ? SEG_BLANK : seg_encode(nibble);
    end
  end

  assign bus.an   = an_r;
  assign bus.seg  = seg_r;
  assign bus.dp   = 1'b1;
  assign bus.busy = conv_busy;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: two instances (blanking on/off) see
// the same value; expected values are queued on drive and checked on completion.
module tb_seg_display_driver;

  localparam int B           = 8;
  localparam int DIGITS      = 8;
  localparam int REFRESH_DIV = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_display_driver_if #(.B(B), .DIGITS(DIGITS)) bus0 ();
  seg_display_driver_if #(.B(B), .DIGITS(DIGITS)) bus1 ();

  seg_display_driver #(.B(B), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_LEADING(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  seg_display_driver #(.B(B), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_LEADING(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int v, input int k, input bit blank);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (blank && k > 0 && v < p) return 7'h7F;
    return pat((v / p) % 10);
  endfunction

  function automatic int dec_an(input logic [7:0] a);
    logic [7:0] sel;
    for (int k = 0; k < 8; k++) begin
      sel = 8'd1 << k;
      if (a == ~sel) return k;
    end
    return -1;
  endfunction

  function automatic logic [7:0] an_for(input int k);
    logic [7:0] sel;
    sel = 8'd1 << k;
    return ~sel;
  endfunction

  task automatic drive(input int v);
    bus0.value = 8'(v);
    bus1.value = 8'(v);
    exp_q.push_back(v);
  endtask

  // Waits for a conversion to finish; display must hold its old value while busy.
  task automatic wait_conv(input string tag, input logic [31:0] prev, output int busy_cycles);
    bit seen;
    bit held;
    seen = 1'b0;
    held = 1'b1;
    busy_cycles = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus0.busy) begin
        seen = 1'b1;
        busy_cycles++;
        if (dut0.disp !== prev) held = 1'b0;
      end else if (seen) begin
        break;
      end
    end
    chk({tag, "_done"}, 32'(seen && !bus0.busy), 32'd1);
    chk({tag, "_hold"}, 32'(held), 32'd1);
  endtask

  // Follows one full scan from digit 0 through 7 and back to 0.
  task automatic scan_check(input string tag, input int v);
    int n;
    n = 0;
    while (bus0.an == 8'hFE && n < 64) begin @(negedge clk); n++; end
    while (bus0.an != 8'hFE && n < 64) begin @(negedge clk); n++; end
    chk({tag, "_align"}, 32'(bus0.an), 32'hFE);
    for (int i = 0; i < 8 * REFRESH_DIV; i++) begin
      chk({tag, "_an0"}, 32'(bus0.an), 32'(an_for(i / REFRESH_DIV)));
      chk({tag, "_an1"}, 32'(bus1.an), 32'(an_for(i / REFRESH_DIV)));
      chk({tag, "_seg0"}, 32'(bus0.seg), 32'(model_seg(v, dec_an(bus0.an), 1'b1)));
      chk({tag, "_seg1"}, 32'(bus1.seg), 32'(model_seg(v, dec_an(bus1.an), 1'b0)));
      @(negedge clk);
    end
    chk({tag, "_wrap"}, 32'(bus0.an), 32'hFE);
    chk({tag, "_dp"}, 32'(bus0.dp), 32'd1);
    chk({tag, "_idle"}, 32'(bus0.busy), 32'd0);
  endtask

  initial begin
    int cycles;
    int v;
    bit any_busy;

    reset = 1'b1;
    bus0.value = '0;
    bus1.value = '0;
    repeat (3) @(negedge clk);
    chk("rst_an0", 32'(bus0.an), 32'hFF);
    chk("rst_seg0", 32'(bus0.seg), 32'h7F);
    chk("rst_dp0", 32'(bus0.dp), 32'd1);
    chk("rst_busy0", 32'(bus0.busy), 32'd0);
    chk("rst_an1", 32'(bus1.an), 32'hFF);
    chk("rst_seg1", 32'(bus1.seg), 32'h7F);

    reset = 1'b0;
    exp_q.push_back(0);
    any_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus0.busy) any_busy = 1'b1;
    end
    chk("zero_no_busy", 32'(any_busy), 32'd0);
    chk("zero_disp", dut0.disp, 32'h0);
    v = exp_q.pop_front();
    scan_check("zero", v);

    drive(255);
    wait_conv("c255", 32'h0, cycles);
    chk("c255_busy_len", 32'(cycles), 32'(B + 2));
    chk("c255_disp", dut0.disp, 32'h0000_0255);
    v = exp_q.pop_front();
    scan_check("v255", v);

    drive(100);
    repeat (2) @(negedge clk);
    drive(7);
    wait_conv("c100", 32'h255, cycles);
    chk("c100_disp", dut0.disp, 32'h100);
    v = exp_q.pop_front();
    @(negedge clk);
    chk("c7_restart", 32'(bus0.busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("v100_seg0", 32'(bus0.seg), 32'(model_seg(v, dec_an(bus0.an), 1'b1)));
      chk("v100_seg1", 32'(bus1.seg), 32'(model_seg(v, dec_an(bus1.an), 1'b0)));
      @(negedge clk);
    end
    wait_conv("c7", 32'h100, cycles);
    chk("c7_disp", dut0.disp, 32'h7);
    v = exp_q.pop_front();
    scan_check("v7", v);

    drive(42);
    repeat (4) @(negedge clk);
    chk("c42_mid_busy", 32'(bus0.busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_an0", 32'(bus0.an), 32'hFF);
    chk("arst_seg0", 32'(bus0.seg), 32'h7F);
    chk("arst_busy0", 32'(bus0.busy), 32'd0);
    chk("arst_an1", 32'(bus1.an), 32'hFF);
    chk("arst_seg1", 32'(bus1.seg), 32'h7F);
    chk("arst_disp", dut0.disp, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_conv("c42", 32'h0, cycles);
    chk("c42_busy_len", 32'(cycles), 32'(B + 2));
    chk("c42_disp", dut0.disp, 32'h42);
    v = exp_q.pop_front();
    scan_check("v42", v);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
